// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the capture-FIFO drain serializer.
// Latency: none (package only).
// Backpressure: none (package only).
package fifo_drain_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      SEND = 2'd3
   } state_t;

   localparam int         DEFAULT_DATA_WIDTH = 48;
   localparam logic [7:0] DEFAULT_SYNC_BYTE  = 8'hA5;
   localparam int         DEFAULT_BYTES      = DEFAULT_DATA_WIDTH / 8;

   // Frame lengths in bytes for the default record width
   localparam int FRAME_LEN_PLAIN = DEFAULT_BYTES + 1;
   localparam int FRAME_LEN_CSUM  = DEFAULT_BYTES + 2;

   // Sync byte + data bytes, plus one trailing checksum byte when enabled
   function automatic int frame_len(input int data_width, input bit csum_en);
      return (data_width / 8) + (csum_en ? 2 : 1);
   endfunction

endpackage

// File: rtl/fifo_drain_serializer.sv
// Drains the capture FIFO one record at a time and emits each as a framed byte stream (sync, data MSB first, optional checksum).
// Latency: first byte valid 2 cycles after the edge that sees !fifo_empty; one byte per cycle while tx_ready is high.
// Backpressure: tx_ready low holds tx_data/tx_valid stable; no new FIFO read until the current frame is fully accepted.
// Optional trailing XOR checksum byte is built in when FIFO_DRAIN_CHECKSUM_EN is defined.
module fifo_drain_serializer
   import fifo_drain_pkg::*;
#(
   parameter int         DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   output logic                  fifo_read_enabled,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_data_out_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic [15:0]           records_sent
);

`ifdef FIFO_DRAIN_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   localparam int            BYTES     = DATA_WIDTH / 8;
   localparam int            FRAME_LEN = frame_len(DATA_WIDTH, CSUM_EN);
   localparam int            IW        = $clog2(FRAME_LEN);
   // idx is the frame position of the byte currently on tx_data (0 = sync)
   localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
`ifdef FIFO_DRAIN_CHECKSUM_EN
   localparam logic [IW-1:0] LAST_DATA_IDX = IW'(BYTES);
`endif

   state_t                state, state_nx;
   logic [DATA_WIDTH-1:0] shreg, shreg_nx;
   logic [IW-1:0]         idx, idx_nx;
   logic [7:0]            tx_data_nx;
   logic                  tx_valid_nx;
   logic                  rd_nx;
   logic                  frame_done;
`ifdef FIFO_DRAIN_CHECKSUM_EN
   logic [7:0]            csum, csum_nx;
`endif

   // Next-state, next-output and datapath update logic
   always_comb begin
      state_nx    = state;
      shreg_nx    = shreg;
      idx_nx      = idx;
      tx_data_nx  = tx_data;
      tx_valid_nx = tx_valid;
      rd_nx       = 1'b0;
      frame_done  = 1'b0;
`ifdef FIFO_DRAIN_CHECKSUM_EN
      csum_nx     = csum;
`endif
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nx = REQ;
               rd_nx    = 1'b1;
            end
         end
         REQ: begin
            state_nx = WAIT;
         end
         WAIT: begin
            if (fifo_data_out_valid) begin
               shreg_nx    = fifo_data_out;
               tx_data_nx  = SYNC_BYTE;
               tx_valid_nx = 1'b1;
               idx_nx      = '0;
               state_nx    = SEND;
`ifdef FIFO_DRAIN_CHECKSUM_EN
               csum_nx     = 8'h00;
`endif
            end else begin
               // FIFO claimed data but returned none: drop back and re-poll
               state_nx = IDLE;
            end
         end
         SEND: begin
            if (tx_valid && tx_ready) begin
               if (idx == LAST_IDX) begin
                  tx_valid_nx = 1'b0;
                  frame_done  = 1'b1;
                  state_nx    = IDLE;
               end else begin
                  idx_nx = idx + 1'b1;
`ifdef FIFO_DRAIN_CHECKSUM_EN
                  if (idx == LAST_DATA_IDX) begin
                     tx_data_nx = csum;
                  end else begin
                     tx_data_nx = shreg[DATA_WIDTH-1 -: 8];
                     shreg_nx   = shreg << 8;
                     csum_nx    = csum ^ shreg[DATA_WIDTH-1 -: 8];
                  end
`else
                  tx_data_nx = shreg[DATA_WIDTH-1 -: 8];
                  shreg_nx   = shreg << 8;
`endif
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         shreg             <= '0;
         idx               <= '0;
         tx_data           <= 8'h00;
         tx_valid          <= 1'b0;
         fifo_read_enabled <= 1'b0;
         busy              <= 1'b0;
         records_sent      <= 16'h0000;
`ifdef FIFO_DRAIN_CHECKSUM_EN
         csum              <= 8'h00;
`endif
      end else begin
         state             <= state_nx;
         shreg             <= shreg_nx;
         idx               <= idx_nx;
         tx_data           <= tx_data_nx;
         tx_valid          <= tx_valid_nx;
         fifo_read_enabled <= rd_nx;
         busy              <= (state_nx != IDLE);
`ifdef FIFO_DRAIN_CHECKSUM_EN
         csum              <= csum_nx;
`endif
         if (frame_done) begin
            records_sent <= records_sent + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Directed bench for fifo_drain_serializer with a behavioural capture-FIFO model and a byte monitor.
// Latency: checks first byte at detection edge + 2 and exact frame spacing.
// Backpressure: tx_ready is either held high or toggled every cycle.
module tb_fifo_drain_serializer;
   import fifo_drain_pkg::*;

`ifdef FIFO_DRAIN_CHECKSUM_EN
   localparam int FL = FRAME_LEN_CSUM;
`else
   localparam int FL = FRAME_LEN_PLAIN;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fifo_empty;
   logic        fifo_read_enabled;
   logic [47:0] fifo_data_out = '0;
   logic        fifo_data_out_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic [15:0] records_sent;

   int vecs = 0;
   int miss = 0;

   fifo_drain_serializer dut (
      .clk                 (clk),
      .reset               (reset),
      .fifo_empty          (fifo_empty),
      .fifo_read_enabled   (fifo_read_enabled),
      .fifo_data_out       (fifo_data_out),
      .fifo_data_out_valid (fifo_data_out_valid),
      .tx_data             (tx_data),
      .tx_valid            (tx_valid),
      .tx_ready            (tx_ready),
      .busy                (busy),
      .records_sent        (records_sent)
   );

   always #5 clk = ~clk;

   // Capture FIFO model: registers read data on the edge that samples the request
   logic [47:0] mem [0:15];
   int  wr_cnt = 0;
   int  rd_cnt = 0;
   int  cyc = 0;
   bit  force_inv = 1'b0;
   assign fifo_empty = (wr_cnt == rd_cnt);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_read_enabled && (rd_cnt != wr_cnt)) begin
         fifo_data_out       <= mem[rd_cnt % 16];
         fifo_data_out_valid <= !force_inv;
         rd_cnt              <= rd_cnt + 1;
      end else begin
         fifo_data_out_valid <= 1'b0;
      end
   end

   // Monitor on the falling edge: log bytes that the next rising edge accepts
   logic [7:0] log_b [0:255];
   int         log_c [0:255];
   int         n_bytes = 0;
   int         n_rd = 0;
   int         stall_viol = 0;
   logic       prev_v = 1'b0;
   logic       prev_r = 1'b0;
   logic [7:0] prev_d = 8'h00;

   always @(negedge clk) begin
      if (fifo_read_enabled) n_rd++;
      if (tx_valid && tx_ready) begin
         log_b[n_bytes] = tx_data;
         log_c[n_bytes] = cyc;
         n_bytes++;
      end
      if (prev_v && !prev_r && !reset && (!tx_valid || tx_data !== prev_d)) stall_viol++;
      prev_v = tx_valid;
      prev_r = tx_ready;
      prev_d = tx_data;
   end

   // tx_ready driver: mode 0 holds it high, mode 1 toggles every cycle
   int ready_mode = 0;
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (ready_mode == 1) tx_ready = ~tx_ready;
         else                 tx_ready = 1'b1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected byte k of the frame for record r with hand-computed checksum cs
   function automatic logic [7:0] exp_byte(input logic [47:0] r, input logic [7:0] cs, input int k);
      if (k == 0) return 8'hA5;
      if (k <= 6) return r[8*(6-k) +: 8];
      return cs;
   endfunction

   task automatic push(input logic [47:0] r);
      mem[wr_cnt % 16] = r;
      wr_cnt++;
   endtask

   task automatic wait_done(input int want_bytes, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (n_bytes >= want_bytes && !busy && fifo_empty) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #2;
      vecs++; if (tx_valid !== 1'b0) begin miss++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
      vecs++; if (tx_data !== 8'h00) begin miss++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
      vecs++; if (busy !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b want 0", busy); end
      vecs++; if (fifo_read_enabled !== 1'b0) begin miss++; $display("FAIL rst_rd: got %b want 0", fifo_read_enabled); end
      vecs++; if (records_sent !== 16'h0000) begin miss++; $display("FAIL rst_count: got %h want 0000", records_sent); end
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic test_single();
      logic [47:0] rec = 48'h0102_0304_0506;
      int base = n_bytes;
      int base_rd = n_rd;
      int pc;
      bit ok;
      ready_mode = 0;
      pc = cyc;
      push(rec);
      wait_done(base + FL, 60, ok);
      vecs++; if (!ok) begin miss++; $display("FAIL single_timeout: got %0d bytes want %0d", n_bytes - base, FL); end
      for (int k = 0; k < FL; k++) begin
         vecs++; if (log_b[base+k] !== exp_byte(rec, 8'h07, k)) begin miss++; $display("FAIL single_byte%0d: got %h want %h", k, log_b[base+k], exp_byte(rec, 8'h07, k)); end
         // detection edge is pc+1, first byte valid two edges later
         vecs++; if (log_c[base+k] !== pc + 3 + k) begin miss++; $display("FAIL single_cyc%0d: got %0d want %0d", k, log_c[base+k], pc + 3 + k); end
      end
      vecs++; if (records_sent !== 16'd1) begin miss++; $display("FAIL single_count: got %0d want 1", records_sent); end
      vecs++; if (n_rd - base_rd !== 1) begin miss++; $display("FAIL single_reads: got %0d want 1", n_rd - base_rd); end
   endtask

   task automatic test_stall();
      logic [47:0] rec = 48'h0102_0304_0506;
      int base = n_bytes;
      int viol0 = stall_viol;
      bit ok;
      ready_mode = 1;
      push(rec);
      wait_done(base + FL, 80, ok);
      ready_mode = 0;
      vecs++; if (!ok) begin miss++; $display("FAIL stall_timeout: got %0d bytes want %0d", n_bytes - base, FL); end
      for (int k = 0; k < FL; k++) begin
         vecs++; if (log_b[base+k] !== exp_byte(rec, 8'h07, k)) begin miss++; $display("FAIL stall_byte%0d: got %h want %h", k, log_b[base+k], exp_byte(rec, 8'h07, k)); end
      end
      // one accept every other cycle: 13 cycles for a 7-byte frame
      vecs++; if (log_c[base+FL-1] - log_c[base] !== 2*FL - 2) begin miss++; $display("FAIL stall_span: got %0d want %0d", log_c[base+FL-1] - log_c[base], 2*FL - 2); end
      vecs++; if (stall_viol - viol0 !== 0) begin miss++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_viol - viol0); end
      vecs++; if (records_sent !== 16'd2) begin miss++; $display("FAIL stall_count: got %0d want 2", records_sent); end
   endtask

   task automatic test_back_to_back();
      logic [47:0] recs [0:2];
      logic [7:0]  css  [0:2];
      int base = n_bytes;
      int base_rd = n_rd;
      bit ok;
      recs[0] = 48'hDEAD_BEEF_0011; css[0] = 8'h33;
      recs[1] = 48'hFF00_FF00_FF00; css[1] = 8'hFF;
      recs[2] = 48'h8001_4002_2004; css[2] = 8'hE7;
      for (int r = 0; r < 3; r++) push(recs[r]);
      wait_done(base + 3*FL, 150, ok);
      vecs++; if (!ok) begin miss++; $display("FAIL b2b_timeout: got %0d bytes want %0d", n_bytes - base, 3*FL); end
      vecs++; if (n_rd - base_rd !== 3) begin miss++; $display("FAIL b2b_reads: got %0d want 3", n_rd - base_rd); end
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < FL; k++) begin
            vecs++; if (log_b[base+r*FL+k] !== exp_byte(recs[r], css[r], k)) begin miss++; $display("FAIL b2b_f%0d_byte%0d: got %h want %h", r, k, log_b[base+r*FL+k], exp_byte(recs[r], css[r], k)); end
         end
      end
      // minimum frame period: REQ + WAIT + load + one IDLE cycle + frame
      for (int r = 1; r < 3; r++) begin
         vecs++; if (log_c[base+r*FL] - log_c[base+(r-1)*FL] !== 3 + FL) begin miss++; $display("FAIL b2b_period%0d: got %0d want %0d", r, log_c[base+r*FL] - log_c[base+(r-1)*FL], 3 + FL); end
      end
      vecs++; if (records_sent !== 16'd5) begin miss++; $display("FAIL b2b_count: got %0d want 5", records_sent); end
   endtask

   task automatic test_spurious();
      int base = n_bytes;
      int base_rd = n_rd;
      bit ok;
      force_inv = 1'b1;
      push(48'h1234_5678_9ABC);
      wait_done(base, 30, ok);
      repeat (3) @(posedge clk);
      #2;
      force_inv = 1'b0;
      vecs++; if (!ok) begin miss++; $display("FAIL spur_timeout: busy=%b want idle", busy); end
      vecs++; if (n_bytes - base !== 0) begin miss++; $display("FAIL spur_bytes: got %0d want 0", n_bytes - base); end
      vecs++; if (n_rd - base_rd !== 1) begin miss++; $display("FAIL spur_reads: got %0d want 1", n_rd - base_rd); end
      vecs++; if (records_sent !== 16'd5) begin miss++; $display("FAIL spur_count: got %0d want 5", records_sent); end
      vecs++; if (busy !== 1'b0) begin miss++; $display("FAIL spur_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_midframe();
      logic [47:0] rec = 48'hCAFE_1234_5678;
      int base = n_bytes;
      bit got4 = 1'b0;
      bit ok;
      push(48'h0A0B_0C0D_0E0F);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         if (n_bytes >= base + 4) begin got4 = 1'b1; break; end
      end
      vecs++; if (!got4) begin miss++; $display("FAIL rmid_timeout: got %0d bytes want 4", n_bytes - base); end
      reset = 1'b1;
      #1;
      vecs++; if (tx_valid !== 1'b0) begin miss++; $display("FAIL rmid_tx_valid: got %b want 0", tx_valid); end
      vecs++; if (busy !== 1'b0) begin miss++; $display("FAIL rmid_busy: got %b want 0", busy); end
      vecs++; if (fifo_read_enabled !== 1'b0) begin miss++; $display("FAIL rmid_rd: got %b want 0", fifo_read_enabled); end
      vecs++; if (records_sent !== 16'd0) begin miss++; $display("FAIL rmid_count: got %0d want 0", records_sent); end
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #2;
      base = n_bytes;
      push(rec);
      wait_done(base + FL, 60, ok);
      vecs++; if (!ok) begin miss++; $display("FAIL rmid_next_timeout: got %0d bytes want %0d", n_bytes - base, FL); end
      for (int k = 0; k < FL; k++) begin
         vecs++; if (log_b[base+k] !== exp_byte(rec, 8'h3C, k)) begin miss++; $display("FAIL rmid_byte%0d: got %h want %h", k, log_b[base+k], exp_byte(rec, 8'h3C, k)); end
      end
      vecs++; if (records_sent !== 16'd1) begin miss++; $display("FAIL rmid_next_count: got %0d want 1", records_sent); end
   endtask

   task automatic test_wrap();
      logic [47:0] rec = 48'h1111_1111_1111;
      int base = n_bytes;
      bit ok;
      force dut.records_sent = 16'hFFFF;
      #1;
      release dut.records_sent;
      #1;
      vecs++; if (records_sent !== 16'hFFFF) begin miss++; $display("FAIL wrap_preload: got %h want ffff", records_sent); end
      push(rec);
      wait_done(base + FL, 60, ok);
      vecs++; if (!ok) begin miss++; $display("FAIL wrap_timeout: got %0d bytes want %0d", n_bytes - base, FL); end
      vecs++; if (log_b[base+FL-1] !== exp_byte(rec, 8'h00, FL-1)) begin miss++; $display("FAIL wrap_last_byte: got %h want %h", log_b[base+FL-1], exp_byte(rec, 8'h00, FL-1)); end
      vecs++; if (records_sent !== 16'h0000) begin miss++; $display("FAIL wrap_count: got %h want 0000", records_sent); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_back_to_back();
      test_spurious();
      test_reset_midframe();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/fifo_drain_serializer.md
# fifo_drain_serializer

Read-side consumer for the capture FIFO. Watches `fifo_empty`, issues single-cycle read requests, and latches each 48-bit record. Each record goes out as a framed byte stream over a valid/ready handshake: sync byte, then data bytes MSB first, then an optional checksum. Sits between the capture FIFO output and the host link transmitter.

## Interface
- `DATA_WIDTH`, 48, record width; must be a multiple of 8 (BYTES = DATA_WIDTH/8).
- `SYNC_BYTE`, 8'hA5, first byte of every frame.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_read_enabled` out 1: read request to the FIFO, registered, one-cycle pulse.
- `fifo_data_out` in DATA_WIDTH: FIFO read data, registered by the FIFO on the edge that samples the request.
- `fifo_data_out_valid` in 1: FIFO read data valid.
- `tx_data` out 8: byte to the link.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: link accepts the byte on a posedge where `tx_valid` && `tx_ready`.
- `busy` out 1: high in any state other than IDLE.
- `records_sent` out 16: count of completed frames; wraps 16'hFFFF→0.

## Operation
- FSM states: IDLE, REQ, WAIT, SEND.
- IDLE: if `!fifo_empty` at an edge, go to REQ and set `fifo_read_enabled`<=1.
- REQ (one cycle): `fifo_read_enabled`<=0, go to WAIT.
- WAIT: sample `fifo_data_out_valid` at the edge.
  - If 1: latch `fifo_data_out` into the shift register, clear the checksum accumulator, `tx_data`<=SYNC_BYTE, `tx_valid`<=1, byte index<=0, go to SEND.
  - If 0 (spurious empty): return to IDLE, nothing emitted, count unchanged.
- SEND: on each edge with `tx_valid`&&`tx_ready`, load the next byte in the same edge (no bubble).
  - Frame order: SYNC_BYTE, data[DATA_WIDTH-1 -: 8] … data[7:0], then the checksum if enabled.
  - While `tx_ready`=0, `tx_data` and `tx_valid` hold stable; `tx_valid` never drops mid-frame.
- After the last byte is accepted: `tx_valid`<=0, `records_sent`<=`records_sent`+1, go to IDLE.
- The checksum covers data bytes only, never SYNC_BYTE.
- Exactly one FIFO read per frame; the block never reads while in SEND.
- Reset values: `fifo_read_enabled`=0, `tx_data`=8'h00, `tx_valid`=0, `busy`=0, `records_sent`=0, state IDLE.
- Reset mid-frame aborts the frame immediately (`tx_valid`=0). The popped record is lost; this is accepted behaviour.

## Timing
- `!fifo_empty` sampled at edge E0 → `fifo_read_enabled` high during E0–E1 → FIFO registers data at E1 → latched at E2.
- `tx_valid`=1 with SYNC_BYTE from E2, i.e. 2 cycles after detection.
- With `tx_ready` held at 1, a frame occupies 1+BYTES(+1) consecutive cycles.
- Frame end to next read request takes at least 1 IDLE cycle, so the minimum frame period is 3+1+BYTES(+1) cycles.
- `busy` is registered and rises at E0.

## Configuration
- `FIFO_DRAIN_CHECKSUM_EN` defined: a trailing byte equal to the XOR of all BYTES data bytes is appended; frame length is BYTES+2.
- Not defined: no checksum byte and no accumulator logic; frame length is BYTES+1.

## Structure
- Package `fifo_drain_pkg`:
  - state enum (IDLE, REQ, WAIT, SEND);
  - default SYNC_BYTE constant;
  - frame-length localparams, with and without checksum.
- Single module; no sub-module warranted. Shift register, byte index, and XOR accumulator are inline.

## Test plan
- One record 48'h0102_0304_0506, `tx_ready`=1 → bytes A5,01,02,03,04,05,06 on consecutive cycles, `tx_valid` first high 2 cycles after `fifo_empty` falls, `records_sent`=1. With the checksum macro, extra byte 07.
- Same record, `tx_ready` toggled 1/0 every cycle → same byte sequence, each byte stable across stalls, frame takes 13 cycles.
- Three records queued back-to-back → exactly three `fifo_read_enabled` pulses, one per frame, frames separated by ≥1 IDLE cycle, `records_sent`=3.
- `fifo_data_out_valid`=0 in WAIT (forced) → no `tx_valid`, return to IDLE, count unchanged.
- `reset` asserted after the third data byte → `tx_valid`, `busy`, `fifo_read_enabled`, `records_sent` all 0 asynchronously; the next record is sent as a full frame starting with A5.
- Preload `records_sent` to 16'hFFFF via 65535 short frames (or force), send one more frame → `records_sent`=0.
